// File: rtl/pmem_port_arbiter_if.sv
// Bundle of the icache, dcache and physical-memory handshakes around the port arbiter.
// The slave view belongs to the arbiter; the master view is the surrounding caches and memory.
interface pmem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256
);
    logic              i_action_stb;
    logic              i_action_cyc;
    logic              i_write;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_wdata;
    logic [DATA_W-1:0] i_rdata;
    logic              i_resp;
    logic              i_retry;

    logic              d_action_stb;
    logic              d_action_cyc;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_resp;
    logic              d_retry;

    logic              mem_action_stb;
    logic              mem_action_cyc;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_resp;
    logic              mem_retry;

    modport slave (
        input  i_action_stb, i_action_cyc, i_write, i_addr, i_wdata,
        input  d_action_stb, d_action_cyc, d_write, d_addr, d_wdata,
        input  mem_rdata, mem_resp, mem_retry,
        output i_rdata, i_resp, i_retry,
        output d_rdata, d_resp, d_retry,
        output mem_action_stb, mem_action_cyc, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output i_action_stb, i_action_cyc, i_write, i_addr, i_wdata,
        output d_action_stb, d_action_cyc, d_write, d_addr, d_wdata,
        output mem_rdata, mem_resp, mem_retry,
        input  i_rdata, i_resp, i_retry,
        input  d_rdata, d_resp, d_retry,
        input  mem_action_stb, mem_action_cyc, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/pmem_port_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between icache and dcache,
// with a latched request and a bounded backoff when memory keeps retrying.
module pmem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 256,
    parameter int MAX_RETRY   = 8,
    parameter int BACKOFF_CYC = 4
) (
    input logic             clk,
    input logic             rst,
    pmem_port_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT_I = 2'd1;
    localparam logic [1:0] ST_GRANT_D = 2'd2;
    localparam logic [1:0] ST_BACKOFF = 2'd3;

    localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
    localparam int BW = (BACKOFF_CYC > 1) ? $clog2(BACKOFF_CYC) : 1;
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);
    localparam logic [BW-1:0] BOFF_LAST  = BW'(BACKOFF_CYC - 1);

    logic [1:0]        state_q, state_d;
    logic              prio_q, prio_d;     // 1: dcache wins a tie
    logic              owner_q, owner_d;   // 1: dcache owns the port
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [RW-1:0]     retry_cnt_q, retry_cnt_d;
    logic [BW-1:0]     boff_cnt_q, boff_cnt_d;

    logic req_i, req_d, pick_d, granted;

    assign req_i   = bus.i_action_stb & bus.i_action_cyc;
    assign req_d   = bus.d_action_stb & bus.d_action_cyc;
    assign pick_d  = req_d & (~req_i | prio_q);
    assign granted = (state_q == ST_GRANT_I) | (state_q == ST_GRANT_D);

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        owner_d     = owner_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        retry_cnt_d = retry_cnt_q;
        boff_cnt_d  = boff_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i | req_d) begin
                    owner_d     = pick_d;
                    write_d     = pick_d ? bus.d_write : bus.i_write;
                    addr_d      = pick_d ? bus.d_addr  : bus.i_addr;
                    wdata_d     = pick_d ? bus.d_wdata : bus.i_wdata;
                    state_d     = pick_d ? ST_GRANT_D  : ST_GRANT_I;
                    retry_cnt_d = '0;
                end
            end
            ST_GRANT_I, ST_GRANT_D: begin
                // Completion wins over retry; the loser of this round gets the next tie.
                if (bus.mem_resp) begin
                    state_d = ST_IDLE;
                    prio_d  = ~owner_q;
                end else if (bus.mem_retry) begin
                    if (retry_cnt_q == RETRY_LAST) begin
                        state_d    = ST_BACKOFF;
                        boff_cnt_d = BOFF_LAST;
                    end else begin
                        retry_cnt_d = retry_cnt_q + RW'(1);
                    end
                end
            end
            ST_BACKOFF: begin
                if (boff_cnt_q == '0) begin
                    state_d     = owner_q ? ST_GRANT_D : ST_GRANT_I;
                    retry_cnt_d = '0;
                end else begin
                    boff_cnt_d = boff_cnt_q - BW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            prio_q      <= 1'b1;
            owner_q     <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            retry_cnt_q <= '0;
            boff_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            owner_q     <= owner_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            retry_cnt_q <= retry_cnt_d;
            boff_cnt_q  <= boff_cnt_d;
        end
    end

    // Memory side is quiet outside a grant, including during backoff.
    assign bus.mem_action_stb = granted;
    assign bus.mem_action_cyc = granted;
    assign bus.mem_write      = granted & write_q;
    assign bus.mem_addr       = granted ? addr_q  : '0;
    assign bus.mem_wdata      = granted ? wdata_q : '0;

    // A requester that dropped its strobe mid-transaction never sees the response.
    assign bus.i_resp  = (state_q == ST_GRANT_I) & bus.mem_resp & req_i;
    assign bus.d_resp  = (state_q == ST_GRANT_D) & bus.mem_resp & req_d;
    assign bus.i_retry = req_i & ~bus.i_resp;
    assign bus.d_retry = req_d & ~bus.d_resp;
    assign bus.i_rdata = bus.mem_rdata;
    assign bus.d_rdata = bus.mem_rdata;
endmodule

// File: tb/tb_pmem_port_arbiter.sv
// Bench for pmem_port_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a behavioural model of the arbitration rules.
module tb_pmem_port_arbiter;
    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 256;
    localparam int MAX_RETRY   = 8;
    localparam int BACKOFF_CYC = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    pmem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RETRY(MAX_RETRY), .BACKOFF_CYC(BACKOFF_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        rst;
        logic        i_stb, i_cyc, i_wr;
        logic [31:0] i_addr;
        logic [255:0] i_wdata;
        logic        d_stb, d_cyc, d_wr;
        logic [31:0] d_addr;
        logic [255:0] d_wdata;
        logic        mem_resp, mem_retry;
        logic [255:0] mem_rdata;
    } drv_t;

    typedef struct {
        logic        rst, ireq, dreq;
        logic [31:0] i_addr, d_addr;
        logic        resp, retry;
        logic        e_stb, e_ir, e_dr;
        logic [31:0] e_addr;
    } vec_t;

    drv_t drv;
    int checks = 0;
    int errors = 0;

    // Behavioural model: who owns the port (-1 none), who wins the next tie,
    // how many retries in a row, and how many quiet backoff cycles remain.
    int           m_owner;
    int           m_tie;
    int           m_streak;
    int           m_left;
    bit           m_boff;
    logic         m_wr;
    logic [31:0]  m_addr;
    logic [255:0] m_wdata;

    logic         smp_stb, smp_ir, smp_dr;
    logic [31:0]  smp_addr;

    task automatic chk_b(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_w(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_tie = 1; m_streak = 0; m_left = 0; m_boff = 0;
        m_wr = 1'b0; m_addr = '0; m_wdata = '0;
    endtask

    task automatic clear_drv();
        drv = '{default: '0};
    endtask

    task automatic step();
        bit ri, rd, e_stb, e_ir, e_dr;
        int w;
        @(negedge clk);
        rst                = drv.rst;
        bus.i_action_stb   = drv.i_stb;
        bus.i_action_cyc   = drv.i_cyc;
        bus.i_write        = drv.i_wr;
        bus.i_addr         = drv.i_addr;
        bus.i_wdata        = drv.i_wdata;
        bus.d_action_stb   = drv.d_stb;
        bus.d_action_cyc   = drv.d_cyc;
        bus.d_write        = drv.d_wr;
        bus.d_addr         = drv.d_addr;
        bus.d_wdata        = drv.d_wdata;
        bus.mem_resp       = drv.mem_resp;
        bus.mem_retry      = drv.mem_retry;
        bus.mem_rdata      = drv.mem_rdata;
        #1;
        ri    = drv.i_stb & drv.i_cyc;
        rd    = drv.d_stb & drv.d_cyc;
        e_stb = (m_owner >= 0) && !m_boff;
        e_ir  = e_stb && (m_owner == 0) && drv.mem_resp && ri;
        e_dr  = e_stb && (m_owner == 1) && drv.mem_resp && rd;
        chk_b("mem_action_stb", bus.mem_action_stb, e_stb);
        chk_b("mem_action_cyc", bus.mem_action_cyc, e_stb);
        chk_b("i_resp", bus.i_resp, e_ir);
        chk_b("d_resp", bus.d_resp, e_dr);
        chk_b("i_retry", bus.i_retry, ri & ~e_ir);
        chk_b("d_retry", bus.d_retry, rd & ~e_dr);
        chk_w("i_rdata", bus.i_rdata, drv.mem_rdata);
        chk_w("d_rdata", bus.d_rdata, drv.mem_rdata);
        if (e_stb) begin
            chk_w("mem_addr", 256'(bus.mem_addr), 256'(m_addr));
            chk_b("mem_write", bus.mem_write, m_wr);
            chk_w("mem_wdata", bus.mem_wdata, m_wdata);
        end
        smp_stb  = bus.mem_action_stb;
        smp_ir   = bus.i_resp;
        smp_dr   = bus.d_resp;
        smp_addr = bus.mem_addr;
        @(posedge clk);
        if (drv.rst) begin
            model_reset();
        end else if (m_owner < 0) begin
            if (ri || rd) begin
                w = (ri && rd) ? m_tie : (rd ? 1 : 0);
                m_owner  = w;
                m_wr     = (w == 1) ? drv.d_wr    : drv.i_wr;
                m_addr   = (w == 1) ? drv.d_addr  : drv.i_addr;
                m_wdata  = (w == 1) ? drv.d_wdata : drv.i_wdata;
                m_streak = 0;
            end
        end else if (m_boff) begin
            m_left--;
            if (m_left == 0) begin
                m_boff   = 0;
                m_streak = 0;
            end
        end else if (drv.mem_resp) begin
            m_tie   = 1 - m_owner;
            m_owner = -1;
        end else if (drv.mem_retry) begin
            m_streak++;
            if (m_streak == MAX_RETRY) begin
                m_boff = 1;
                m_left = BACKOFF_CYC;
            end
        end
    endtask

    function automatic vec_t mk(logic r, logic ir, logic dr, logic [31:0] ia, logic [31:0] da,
                                logic rs, logic rt, logic es, logic eir, logic edr,
                                logic [31:0] ea);
        vec_t v;
        v.rst = r; v.ireq = ir; v.dreq = dr; v.i_addr = ia; v.d_addr = da;
        v.resp = rs; v.retry = rt; v.e_stb = es; v.e_ir = eir; v.e_dr = edr; v.e_addr = ea;
        return v;
    endfunction

    vec_t tbl[15];
    int   lowcnt;
    int   seg_heavy;

    initial begin
        tbl[0]  = mk(1, 0, 0, 32'h000, 32'h000, 0, 0, 0, 0, 0, 32'h000);
        tbl[1]  = mk(0, 1, 0, 32'h100, 32'h000, 0, 0, 0, 0, 0, 32'h000);
        tbl[2]  = mk(0, 1, 0, 32'h100, 32'h000, 0, 0, 1, 0, 0, 32'h100);
        tbl[3]  = mk(0, 1, 0, 32'h100, 32'h000, 1, 0, 1, 1, 0, 32'h100);
        tbl[4]  = mk(0, 0, 0, 32'h100, 32'h000, 0, 0, 0, 0, 0, 32'h000);
        tbl[5]  = mk(0, 1, 1, 32'h111, 32'h222, 0, 0, 0, 0, 0, 32'h000);
        tbl[6]  = mk(0, 1, 1, 32'h111, 32'h222, 0, 0, 1, 0, 0, 32'h222);
        tbl[7]  = mk(0, 1, 1, 32'h111, 32'h222, 1, 0, 1, 0, 1, 32'h222);
        tbl[8]  = mk(0, 1, 1, 32'h111, 32'h222, 0, 0, 0, 0, 0, 32'h000);
        tbl[9]  = mk(0, 1, 1, 32'h111, 32'h222, 0, 0, 1, 0, 0, 32'h111);
        tbl[10] = mk(0, 1, 1, 32'h111, 32'h222, 1, 0, 1, 1, 0, 32'h111);
        tbl[11] = mk(0, 1, 1, 32'h111, 32'h222, 0, 0, 0, 0, 0, 32'h000);
        tbl[12] = mk(0, 1, 1, 32'h111, 32'h222, 0, 0, 1, 0, 0, 32'h222);
        tbl[13] = mk(0, 1, 1, 32'h111, 32'h222, 1, 0, 1, 0, 1, 32'h222);
        tbl[14] = mk(0, 0, 0, 32'h111, 32'h222, 0, 0, 0, 0, 0, 32'h000);

        clear_drv();
        rst = 1'b1;
        bus.i_action_stb = 1'b0; bus.i_action_cyc = 1'b0; bus.i_write = 1'b0;
        bus.i_addr = '0; bus.i_wdata = '0;
        bus.d_action_stb = 1'b0; bus.d_action_cyc = 1'b0; bus.d_write = 1'b0;
        bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_resp = 1'b0; bus.mem_retry = 1'b0; bus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        model_reset();

        // Directed table: reset, lone icache read, then I/D ties alternating from D.
        for (int n = 0; n < 15; n++) begin
            clear_drv();
            drv.rst       = tbl[n].rst;
            drv.i_stb     = tbl[n].ireq;
            drv.i_cyc     = tbl[n].ireq;
            drv.i_addr    = tbl[n].i_addr;
            drv.i_wdata   = {8{32'hA5A5_0000 + n}};
            drv.d_stb     = tbl[n].dreq;
            drv.d_cyc     = tbl[n].dreq;
            drv.d_addr    = tbl[n].d_addr;
            drv.d_wdata   = {8{32'h5A5A_0000 + n}};
            drv.mem_resp  = tbl[n].resp;
            drv.mem_retry = tbl[n].retry;
            drv.mem_rdata = rnd256();
            step();
            chk_b($sformatf("tbl%0d_stb", n), smp_stb, tbl[n].e_stb);
            chk_b($sformatf("tbl%0d_i_resp", n), smp_ir, tbl[n].e_ir);
            chk_b($sformatf("tbl%0d_d_resp", n), smp_dr, tbl[n].e_dr);
            if (tbl[n].e_stb)
                chk_w($sformatf("tbl%0d_addr", n), 256'(smp_addr), 256'(tbl[n].e_addr));
        end

        // dcache write whose address moves while granted: latched address must hold.
        clear_drv();
        drv.d_stb = 1; drv.d_cyc = 1; drv.d_wr = 1; drv.d_addr = 32'h2000;
        drv.d_wdata = {8{32'hDEAD_BEEF}};
        step();
        drv.d_addr = 32'h3000; drv.d_wdata = {8{32'h0BAD_F00D}};
        for (int k = 0; k < 3; k++) begin
            step();
            chk_w("t3_addr_hold", 256'(smp_addr), 256'(32'h2000));
        end
        drv.mem_resp = 1;
        step();
        chk_b("t3_d_resp", smp_dr, 1'b1);
        chk_w("t3_addr_at_resp", 256'(smp_addr), 256'(32'h2000));
        clear_drv();
        step();

        // Eight retries in a row: stb low for exactly the backoff length, then reissue.
        drv.i_stb = 1; drv.i_cyc = 1; drv.i_addr = 32'h4000; drv.i_wdata = {8{32'h1234_5678}};
        step();
        drv.mem_retry = 1;
        repeat (MAX_RETRY) step();
        drv.mem_retry = 0;
        lowcnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (smp_stb) break;
            lowcnt++;
        end
        chk_w("t4_backoff_len", 256'(lowcnt), 256'(BACKOFF_CYC));
        chk_b("t4_reissue_stb", smp_stb, 1'b1);
        chk_w("t4_reissue_addr", 256'(smp_addr), 256'(32'h4000));
        drv.mem_resp = 1;
        step();
        chk_b("t4_i_resp", smp_ir, 1'b1);
        clear_drv();
        step();

        // mem_resp and mem_retry together complete the transaction.
        drv.i_stb = 1; drv.i_cyc = 1; drv.i_addr = 32'h5000;
        step();
        drv.mem_resp = 1; drv.mem_retry = 1;
        step();
        chk_b("t5_i_resp", smp_ir, 1'b1);
        clear_drv();
        step();
        chk_b("t5_idle_stb", smp_stb, 1'b0);

        // Reset while icache is granted; a late mem_resp must be ignored.
        drv.i_stb = 1; drv.i_cyc = 1; drv.i_addr = 32'h6000;
        step();
        step();
        drv.rst = 1;
        step();
        clear_drv();
        step();
        chk_b("t6_stb_after_rst", smp_stb, 1'b0);
        drv.mem_resp = 1;
        step();
        chk_b("t6_no_i_resp", smp_ir, 1'b0);
        chk_b("t6_no_d_resp", smp_dr, 1'b0);
        clear_drv();
        step();

        // Randomized traffic, alternating calm and retry-heavy memory phases.
        seg_heavy = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 60 == 0) seg_heavy = ($urandom_range(0, 2) == 0) ? 1 : 0;
            drv.rst   = ($urandom_range(0, 199) == 0);
            drv.i_stb = ($urandom_range(0, 2) != 0);
            drv.i_cyc = ($urandom_range(0, 7) == 0) ? 1'($urandom_range(0, 1)) : drv.i_stb;
            drv.i_wr  = 1'($urandom_range(0, 1));
            drv.i_addr  = $urandom();
            drv.i_wdata = rnd256();
            drv.d_stb = ($urandom_range(0, 2) != 0);
            drv.d_cyc = ($urandom_range(0, 7) == 0) ? 1'($urandom_range(0, 1)) : drv.d_stb;
            drv.d_wr  = 1'($urandom_range(0, 1));
            drv.d_addr  = $urandom();
            drv.d_wdata = rnd256();
            if (seg_heavy != 0) begin
                drv.mem_retry = ($urandom_range(0, 9) != 0);
                drv.mem_resp  = ($urandom_range(0, 24) == 0);
            end else begin
                drv.mem_retry = ($urandom_range(0, 3) == 0);
                drv.mem_resp  = ($urandom_range(0, 2) == 0);
            end
            drv.mem_rdata = rnd256();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
